// File: rtl/light_sensor_pkg.sv
// Shared defaults and limits for the light sensor array and its per-channel debouncer.
package light_sensor_pkg;

  localparam int unsigned MAX_CH              = 16;
  localparam int unsigned DEF_N_CH            = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W           = 16;
  localparam bit          DEF_DO_ACTIVE_LOW   = 1'b1;

endpackage

// File: rtl/light_debounce_ch.sv
// One sensor channel: 2-flop synchroniser, stable-level debounce counter and
// registered rise/fall pulses coincident with the new debounced level.
module light_debounce_ch
  import light_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          DO_ACTIVE_LOW   = DEF_DO_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic i_do,
  output logic o_light,
  output logic o_on_pulse,
  output logic o_off_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_light;
  logic          r_on_pulse;
  logic          r_off_pulse;

  logic w_raw_light;
  logic w_differs;
  logic w_accept;

  assign w_raw_light = r_sync2 ^ DO_ACTIVE_LOW;
  assign w_differs   = (w_raw_light != r_light);
  // Accept on the edge where the count would reach DEBOUNCE_CYCLES.
  assign w_accept    = w_differs && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= DO_ACTIVE_LOW;
      r_sync2     <= DO_ACTIVE_LOW;
      r_cnt       <= '0;
      r_light     <= 1'b0;
      r_on_pulse  <= 1'b0;
      r_off_pulse <= 1'b0;
    end else begin
      r_sync1     <= i_do;
      r_sync2     <= r_sync1;
      r_on_pulse  <= w_accept && !r_light;
      r_off_pulse <= w_accept && r_light;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_light <= ~r_light;
      end
    end
  end

  assign o_light     = r_light;
  assign o_on_pulse  = r_on_pulse;
  assign o_off_pulse = r_off_pulse;

endmodule

// File: rtl/light_sensor_array.sv
// Array of independent debounced light sensors with sticky event flags and
// saturating per-channel on-event counters.
module light_sensor_array
  import light_sensor_pkg::*;
#(
  parameter int unsigned N_CH            = DEF_N_CH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter bit          DO_ACTIVE_LOW   = DEF_DO_ACTIVE_LOW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       do_in,
  input  logic [N_CH-1:0]       event_clear,
  input  logic                  count_clear,
  output logic [N_CH-1:0]       light_detected,
  output logic [N_CH-1:0]       light_on_pulse,
  output logic [N_CH-1:0]       light_off_pulse,
  output logic [N_CH-1:0]       event_pending,
  output logic [N_CH*CNT_W-1:0] on_count,
  output logic                  any_light
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             r_pending;
    logic [CNT_W-1:0] r_count;

    light_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DO_ACTIVE_LOW  (DO_ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_do       (do_in[g]),
      .o_light    (light_detected[g]),
      .o_on_pulse (light_on_pulse[g]),
      .o_off_pulse(light_off_pulse[g])
    );

    // A new event wins over a coincident clear, for both the flag and the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pending <= 1'b0;
        r_count   <= '0;
      end else begin
        if (light_on_pulse[g]) begin
          r_pending <= 1'b1;
        end else if (event_clear[g]) begin
          r_pending <= 1'b0;
        end
        if (count_clear) begin
          r_count <= light_on_pulse[g] ? CNT_W'(1) : '0;
        end else if (light_on_pulse[g] && (r_count != '1)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end

    assign event_pending[g]            = r_pending;
    assign on_count[g*CNT_W +: CNT_W]  = r_count;
  end

  assign any_light = |light_detected;

endmodule

// File: tb/tb_light_sensor_array.sv
// Directed bench for light_sensor_array with N_CH=4, DEBOUNCE_CYCLES=8, CNT_W=4, active-low DO.
module tb_light_sensor_array;

  logic        clk;
  logic        rst;
  logic [3:0]  do_in;
  logic [3:0]  event_clear;
  logic        count_clear;
  logic [3:0]  light_detected;
  logic [3:0]  light_on_pulse;
  logic [3:0]  light_off_pulse;
  logic [3:0]  event_pending;
  logic [15:0] on_count;
  logic        any_light;

  int n_checks = 0;
  int n_fail   = 0;

  light_sensor_array #(
    .N_CH           (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .DO_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .do_in          (do_in),
    .event_clear    (event_clear),
    .count_clear    (count_clear),
    .light_detected (light_detected),
    .light_on_pulse (light_on_pulse),
    .light_off_pulse(light_off_pulse),
    .event_pending  (event_pending),
    .on_count       (on_count),
    .any_light      (any_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; do_in = 4'hF; event_clear = 4'h0; count_clear = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({light_detected, light_on_pulse, light_off_pulse, event_pending, on_count, any_light} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ld=%b on=%b off=%b ep=%b cnt=%h any=%b, expected all zero",
               light_detected, light_on_pulse, light_off_pulse, event_pending, on_count, any_light);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({light_detected, light_on_pulse, light_off_pulse, event_pending, on_count, any_light} !== 33'd0)
        bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_release_quiet: got %0d non-idle cycles, expected 0", bad);
    end
  endtask

  task automatic test_light_on();
    int early;
    tick();
    do_in[0] = 1'b0;
    early = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (light_detected[0] !== 1'b0 || light_on_pulse[0] !== 1'b0) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL on_latency_early: got %0d early cycles, expected 0", early);
    end
    tick();
    n_checks++;
    if (light_detected !== 4'b0001 || light_on_pulse !== 4'b0001 || any_light !== 1'b1) begin
      n_fail++;
      $display("FAIL on_edge_10: got ld=%b on=%b any=%b, expected ld=0001 on=0001 any=1",
               light_detected, light_on_pulse, any_light);
    end
    tick();
    n_checks++;
    if (light_on_pulse !== 4'b0000 || on_count !== 16'h0001 || event_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL on_after: got on=%b cnt=%h ep=%b, expected on=0000 cnt=0001 ep=0001",
               light_on_pulse, on_count, event_pending);
    end
    repeat (9) tick();
    n_checks++;
    if (light_detected !== 4'b0001 || on_count !== 16'h0001 || light_off_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL on_hold: got ld=%b cnt=%h off=%b, expected ld=0001 cnt=0001 off=0000",
               light_detected, on_count, light_off_pulse);
    end
  endtask

  task automatic test_glitch();
    int bad;
    int n_on;
    int n_off;
    tick();
    do_in[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (light_detected[1] !== 1'b0 || light_on_pulse[1] !== 1'b0 || light_off_pulse[1] !== 1'b0) bad++;
    end
    do_in[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (light_detected[1] !== 1'b0 || light_on_pulse[1] !== 1'b0 || light_off_pulse[1] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || on_count[7:4] !== 4'd0) begin
      n_fail++;
      $display("FAIL glitch_7: got %0d active cycles cnt1=%0d, expected 0 and 0", bad, on_count[7:4]);
    end
    // An 8-cycle pulse is just long enough to be accepted.
    do_in[1] = 1'b0;
    n_on = 0; n_off = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (light_on_pulse[1] === 1'b1) n_on++;
      if (light_off_pulse[1] === 1'b1) n_off++;
    end
    do_in[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (light_on_pulse[1] === 1'b1) n_on++;
      if (light_off_pulse[1] === 1'b1) n_off++;
    end
    n_checks++;
    if (n_on !== 1 || n_off !== 1 || on_count[7:4] !== 4'd1 || event_pending !== 4'b0011) begin
      n_fail++;
      $display("FAIL pulse_8: got on=%0d off=%0d cnt1=%0d ep=%b, expected 1 1 1 0011",
               n_on, n_off, on_count[7:4], event_pending);
    end
  endtask

  task automatic test_saturate();
    int n_on;
    int n_off;
    int exp_cnt;
    n_on = 0; n_off = 0;
    for (int p = 1; p <= 20; p++) begin
      do_in[2] = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (light_on_pulse[2] === 1'b1) n_on++;
        if (light_off_pulse[2] === 1'b1) n_off++;
      end
      do_in[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (light_on_pulse[2] === 1'b1) n_on++;
        if (light_off_pulse[2] === 1'b1) n_off++;
      end
      exp_cnt = (p > 15) ? 15 : p;
      n_checks++;
      if (on_count[11:8] !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_count_p%0d: got %0d, expected %0d", p, on_count[11:8], exp_cnt);
      end
    end
    n_checks++;
    if (n_on !== 20 || n_off !== 20) begin
      n_fail++;
      $display("FAIL sat_pulses: got on=%0d off=%0d, expected 20 20", n_on, n_off);
    end
  endtask

  task automatic test_clear_coincident();
    event_clear = 4'b0001;
    tick();
    event_clear = 4'b0000;
    n_checks++;
    if (event_pending !== 4'b0110) begin
      n_fail++;
      $display("FAIL event_clear: got ep=%b, expected 0110", event_pending);
    end
    do_in[0] = 1'b1;
    repeat (20) tick();
    do_in[0] = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (light_on_pulse !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_pulse_edge: got on=%b, expected 0001", light_on_pulse);
    end
    event_clear = 4'b0001;
    count_clear = 1'b1;
    tick();
    event_clear = 4'b0000;
    count_clear = 1'b0;
    n_checks++;
    if (event_pending !== 4'b0111 || on_count !== 16'h0001) begin
      n_fail++;
      $display("FAIL clear_coincident: got ep=%b cnt=%h, expected ep=0111 cnt=0001",
               event_pending, on_count);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int early;
    tick();
    do_in[3] = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (light_detected !== 4'b0000 || on_count !== 16'h0000 || event_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_state: got ld=%b cnt=%h ep=%b, expected all zero",
               light_detected, on_count, event_pending);
    end
    early = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (light_detected !== 4'b0000 || light_on_pulse !== 4'b0000) early++;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_early: got %0d early cycles, expected 0", early);
    end
    tick();
    n_checks++;
    if (light_detected !== 4'b1001 || light_on_pulse !== 4'b1001 || any_light !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_edge: got ld=%b on=%b any=%b, expected 1001 1001 1",
               light_detected, light_on_pulse, any_light);
    end
    tick();
    n_checks++;
    if (on_count !== 16'h1001 || event_pending !== 4'b1001 || light_on_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_after: got cnt=%h ep=%b on=%b, expected 1001 1001 0000",
               on_count, event_pending, light_on_pulse);
    end
  endtask

  task automatic test_multi_off();
    do_in = 4'hF;
    repeat (9) tick();
    n_checks++;
    if (light_detected !== 4'b1001 || light_off_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL multi_off_early: got ld=%b off=%b, expected 1001 0000", light_detected, light_off_pulse);
    end
    tick();
    n_checks++;
    if (light_detected !== 4'b0000 || light_off_pulse !== 4'b1001 || any_light !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_off_edge: got ld=%b off=%b any=%b, expected 0000 1001 0",
               light_detected, light_off_pulse, any_light);
    end
  endtask

  initial begin
    test_reset();
    test_light_on();
    test_glitch();
    test_saturate();
    test_clear_coincident();
    test_reset_mid_debounce();
    test_multi_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_sensor_array.md
LIGHT_SENSOR_ARRAY -- requirements
Module: light_sensor_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent sensor channels, 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles needed to accept a new level, minimum 2.
REQ-003 Parameter CNT_W, default 16: width of each per-channel on-event counter.
REQ-004 Parameter DO_ACTIVE_LOW, default 1: 1 = sensor DO low means light; 0 = DO high means light.
REQ-005 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 do_in  in  N_CH  raw asynchronous sensor DO pins, bit i = channel i.
REQ-008 event_clear  in  N_CH  per-channel clear of event_pending.
REQ-009 count_clear  in  1  clears all on_count fields.
REQ-010 light_detected  out  N_CH  debounced light level, 1 = light.
REQ-011 light_on_pulse  out  N_CH  one-cycle pulse on accepted dark-to-light transition.
REQ-012 light_off_pulse  out  N_CH  one-cycle pulse on accepted light-to-dark transition.
REQ-013 event_pending  out  N_CH  sticky flag, set by light_on_pulse.
REQ-014 on_count  out  N_CH*CNT_W  saturating on-event count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-015 any_light  out  1  OR of light_detected.

Function
REQ-016 Each do_in bit SHALL pass through a 2-flop synchroniser; raw_light = sync2 XOR DO_ACTIVE_LOW.
REQ-017 Per channel, counter width $clog2(DEBOUNCE_CYCLES+1); counter SHALL reset to 0 on any cycle where raw_light equals light_detected.
REQ-018 While raw_light differs from light_detected, the counter SHALL increment; on the edge where it would reach DEBOUNCE_CYCLES, light_detected SHALL toggle and the counter SHALL return to 0.
REQ-019 Latency from a clean do_in transition (setup met) to light_detected change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-020 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-021 light_on_pulse/light_off_pulse SHALL be high for exactly the one cycle after the edge where light_detected rose/fell (registered, coincident with the new light_detected value).
REQ-022 event_pending[i] SHALL set on light_on_pulse[i] and clear on event_clear[i]; a simultaneous set and clear SHALL leave it set.
REQ-023 on_count[i] SHALL increment by 1 on each light_on_pulse[i], saturating at 2^CNT_W-1 without wrap.
REQ-024 count_clear SHALL zero all counts; when coincident with light_on_pulse[i], on_count[i] SHALL become 1.
REQ-025 any_light SHALL be combinational from light_detected, with no additional latency.
REQ-026 Channels SHALL be fully independent; simultaneous transitions on multiple channels SHALL each be reported in the same cycle.

Reset
REQ-027 While rst is high: synchronisers load the dark level (DO_ACTIVE_LOW value), debounce counters 0, light_detected 0, pulses 0, event_pending 0, on_count 0.
REQ-028 Reset asserted mid-debounce SHALL discard progress; after release, a light level present on do_in SHALL require the full DEBOUNCE_CYCLES+2 cycles, then produce one light_on_pulse.
REQ-029 Releasing reset with do_in at the dark level SHALL produce no pulse.

Structure
REQ-030 Package light_sensor_pkg SHALL hold the parameter defaults and the max-channel constant (16).
REQ-031 Per-channel synchroniser, debounce and edge logic SHALL be sub-module light_debounce_ch, instantiated N_CH times in a generate loop; event flags and counters SHALL reside in the top level.

Verification (N_CH=4, DEBOUNCE_CYCLES=8, CNT_W=4, DO_ACTIVE_LOW=1)
REQ-032 Reset with do_in=4'b1111 held 5 cycles, then released -> all outputs 0, no pulses for 50 cycles.
REQ-033 do_in[0] driven 0 and held 20 cycles -> light_detected[0] rises exactly 10 cycles later; light_on_pulse[0] high 1 cycle; on_count[0]=1; event_pending[0]=1; any_light=1.
REQ-034 do_in[1] driven 0 for 7 cycles, then 1 -> light_detected[1], pulses and on_count[1] unchanged.
REQ-035 20 clean 20-cycle light/dark periods on channel 2 -> on_count[2]=15 (saturated), 20 light_off_pulse[2] pulses.
REQ-036 event_clear[0] and count_clear asserted in the light_on_pulse[0] cycle -> event_pending[0] stays 1; on_count[0]=1.
REQ-037 rst pulsed at debounce count 5 on channel 3, do_in[3] held 0 -> light_detected[3] rises exactly 10 cycles after rst release.
